// File: rtl/fifo_seq_ctrl.sv
// fifo_seq_ctrl: sequencer for the delay-buffer fifo bank in front of the
// systolic MAC array. It loads rows from the host, feeds them with a
// diagonal skew, drains the array and then pulses done.
module fifo_seq_ctrl #(
    parameter int ROWS  = 8,
    parameter int DEPTH = 8,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_wr_valid,
    input  logic [RW-1:0]   i_wr_row,
    output logic            o_wr_ready,
    input  logic            i_start,
    output logic [ROWS-1:0] o_fifo_en,
    output logic            o_zero_fill,
    output logic [ROWS-1:0] o_lane_valid,
    output logic            o_mac_en,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(DEPTH + ROWS);
    localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [TW-1:0] T_LAST    = TW'(DEPTH + ROWS - 2);
    localparam logic [DW-1:0] D_LAST    = DW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ROWS-1:0][FW-1:0] r_fill;
    logic [TW-1:0]          r_t;
    logic [DW-1:0]          r_d;
    logic                   r_err;

    logic                   w_row_ok;
    logic [FW-1:0]          w_row_fill;
    logic                   w_all_full;
    logic [ROWS-1:0]        w_feed_mask;
    logic                   w_wr_acc;
    logic                   w_start_acc;
    logic                   w_err_set;

    // Rows beyond ROWS are only reachable when ROWS is not a power of two.
    assign w_row_ok = (int'(i_wr_row) < ROWS);
    assign o_busy   = (r_state != S_LOAD);
    assign o_err    = r_err;

    // Fill level of the addressed row, zero when the row index is invalid.
    always_comb begin
        w_row_fill = '0;
        if (w_row_ok) w_row_fill = r_fill[i_wr_row];
    end

    // Start is only legal once every row holds a full DEPTH of operands.
    always_comb begin
        w_all_full = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            if (r_fill[i] != FILL_FULL) w_all_full = 1'b0;
        end
    end

    // Diagonal skew: lane i shifts during feed steps i .. i+DEPTH-1.
    always_comb begin
        w_feed_mask = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_feed_mask[i] = (int'(r_t) >= i) && (int'(r_t) < i + DEPTH);
        end
    end

    // Next-state and per-cycle output decode.
    always_comb begin
        w_state_nxt  = r_state;
        o_wr_ready   = 1'b0;
        o_fifo_en    = '0;
        o_lane_valid = '0;
        o_zero_fill  = 1'b0;
        o_mac_en     = 1'b0;
        o_done       = 1'b0;
        w_wr_acc     = 1'b0;
        w_start_acc  = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            S_LOAD: begin
                o_wr_ready = 1'b1;
                if (i_wr_valid) begin
                    if (w_row_ok && (w_row_fill < FILL_FULL)) begin
                        w_wr_acc            = 1'b1;
                        o_fifo_en[i_wr_row] = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                // The full check sees pre-write fill levels, so a start
                // paired with the last write is rejected.
                if (i_start) begin
                    if (w_all_full) begin
                        w_start_acc = 1'b1;
                        w_state_nxt = S_FEED;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_FEED: begin
                o_fifo_en    = w_feed_mask;
                o_lane_valid = w_feed_mask;
                o_zero_fill  = 1'b1;
                o_mac_en     = 1'b1;
                if (r_t == T_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                o_mac_en = 1'b1;
                if (r_d == D_LAST) w_state_nxt = S_DONE;
            end
            default: begin
                o_done      = 1'b1;
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // State register; clear behaves exactly like reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) r_state <= S_LOAD;
        else                     r_state <= w_state_nxt;
    end

    // Fill, feed-step and drain counters plus the sticky error flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_fill <= '0;
            r_t    <= '0;
            r_d    <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_err_set) r_err <= 1'b1;
            case (r_state)
                S_LOAD: begin
                    if (w_wr_acc) r_fill[i_wr_row] <= w_row_fill + FW'(1);
                    if (w_start_acc) r_t <= '0;
                end
                S_FEED: begin
                    // Zero-fill during feed leaves every fifo empty of data.
                    if (r_t == T_LAST) begin
                        r_fill <= '0;
                        r_d    <= '0;
                    end else begin
                        r_t <= r_t + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_d != D_LAST) r_d <= r_d + DW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Directed bench for fifo_seq_ctrl (ROWS=DEPTH=8): vector table for basic
// LOAD behaviour, hand sequences for full load/feed/drain and corner cases.
module tb_fifo_seq_ctrl;

    logic       clk;
    logic       rst_n, clear, wr_valid, start;
    logic [2:0] wr_row;
    logic       o_wr_ready, o_zero_fill, o_mac_en, o_busy, o_done, o_err;
    logic [7:0] o_fifo_en, o_lane_valid;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_seq_ctrl #(.ROWS(8), .DEPTH(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clear),
        .i_wr_valid   (wr_valid),
        .i_wr_row     (wr_row),
        .o_wr_ready   (o_wr_ready),
        .i_start      (start),
        .o_fifo_en    (o_fifo_en),
        .o_zero_fill  (o_zero_fill),
        .o_lane_valid (o_lane_valid),
        .o_mac_en     (o_mac_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        clear;
        logic        wr_valid;
        logic [2:0]  wr_row;
        logic        start;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[14];

    // {wr_ready, fifo_en, lane_valid, zero_fill, mac_en, busy, done, err}
    function automatic logic [21:0] eo(logic rdy, logic [7:0] fen, logic [7:0] lv,
                                       logic zf, logic mac, logic bsy, logic dn, logic er);
        return {rdy, fen, lv, zf, mac, bsy, dn, er};
    endfunction

    function automatic logic [21:0] e_load(logic [7:0] fen, logic er);
        return eo(1'b1, fen, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, er);
    endfunction

    function automatic logic [21:0] e_feed(logic [7:0] m, logic er);
        return eo(1'b0, m, m, 1'b1, 1'b1, 1'b1, 1'b0, er);
    endfunction

    function automatic logic [21:0] e_drain(logic er);
        return eo(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, er);
    endfunction

    function automatic logic [21:0] e_done(logic er);
        return eo(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, er);
    endfunction

    // Lane i is active for feed steps i..i+7.
    function automatic logic [7:0] feed_mask(int t);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) m[i] = (t >= i) && (t < i + 8);
        return m;
    endfunction

    task automatic drive(input logic rn, input logic cl, input logic wv,
                         input logic [2:0] wr, input logic st);
        rst_n = rn; clear = cl; wr_valid = wv; wr_row = wr; start = st;
    endtask

    task automatic check(input string nm, input logic [21:0] exp);
        logic [21:0] act;
        act = {o_wr_ready, o_fifo_en, o_lane_valid, o_zero_fill, o_mac_en,
               o_busy, o_done, o_err};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rn, input logic cl, input logic wv,
                        input logic [2:0] wr, input logic st,
                        input logic [21:0] exp, input string nm);
        drive(rn, cl, wv, wr, st);
        #4;
        check(nm, exp);
        tick();
    endtask

    task automatic fill_row(input int row, input int n, input logic er);
        for (int k = 0; k < n; k++)
            step(1, 0, 1, 3'(row), 0, e_load(8'(1 << row), er),
                 $sformatf("load r%0d k%0d", row, k));
    endtask

    // Cycles following an accepted start: 15 FEED, 8 DRAIN, 1 DONE, then LOAD.
    // Start and writes are sprinkled in to confirm they are ignored.
    task automatic run_seq(input logic er);
        int done_cnt;
        int done_at;
        logic [21:0] e;
        logic wv;
        logic st;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= 25; c++) begin
            st = (c == 3) || (c == 18);
            wv = (c == 5) || (c == 20);
            if (c <= 15)      e = e_feed(feed_mask(c - 1), er);
            else if (c <= 23) e = e_drain(er);
            else if (c == 24) e = e_done(er);
            else              e = e_load(8'h00, er);
            drive(1, 0, wv, 3'd2, st);
            #4;
            check($sformatf("seq c%0d", c), e);
            if (o_done) begin
                done_cnt++;
                done_at = c;
            end
            case (c - 1)
                0:  check_int("skew t0",  int'(o_fifo_en), 'h01);
                3:  check_int("skew t3",  int'(o_fifo_en), 'h0F);
                7:  check_int("skew t7",  int'(o_fifo_en), 'hFF);
                10: check_int("skew t10", int'(o_fifo_en), 'hF8);
                14: check_int("skew t14", int'(o_fifo_en), 'h80);
                default: ;
            endcase
            tick();
        end
        check_int("done count", done_cnt, 1);
        check_int("done cycle", done_at, 24);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 3'd0, 0, e_load(8'h00, 0)};
        tbl[1]  = '{1, 0, 1, 3'd2, 0, e_load(8'h04, 0)};
        tbl[2]  = '{1, 0, 1, 3'd5, 0, e_load(8'h20, 0)};
        tbl[3]  = '{1, 0, 0, 3'd0, 1, e_load(8'h00, 0)};
        tbl[4]  = '{1, 0, 0, 3'd0, 0, e_load(8'h00, 1)};
        tbl[5]  = '{1, 1, 0, 3'd0, 0, e_load(8'h00, 1)};
        tbl[6]  = '{1, 0, 0, 3'd0, 0, e_load(8'h00, 0)};
        tbl[7]  = '{1, 0, 1, 3'd2, 1, e_load(8'h04, 0)};
        tbl[8]  = '{1, 0, 0, 3'd0, 0, e_load(8'h00, 1)};
        tbl[9]  = '{0, 0, 0, 3'd0, 0, e_load(8'h00, 1)};
        tbl[10] = '{1, 0, 0, 3'd0, 0, e_load(8'h00, 0)};
        tbl[11] = '{1, 0, 1, 3'd6, 0, e_load(8'h40, 0)};
        tbl[12] = '{1, 1, 0, 3'd0, 0, e_load(8'h00, 0)};
        tbl[13] = '{1, 0, 0, 3'd0, 0, e_load(8'h00, 0)};

        drive(0, 0, 0, 3'd0, 0);
        repeat (2) @(posedge clk);
        #1;

        // reset state and basic LOAD behaviour
        for (int i = 0; i < 14; i++)
            step(tbl[i].rst_n, tbl[i].clear, tbl[i].wr_valid, tbl[i].wr_row,
                 tbl[i].start, tbl[i].exp, $sformatf("tbl[%0d]", i));

        // full load, start, feed/drain/done timing
        for (int r = 0; r < 8; r++) fill_row(r, 8, 0);
        step(1, 0, 0, 3'd0, 1, e_load(8'h00, 0), "start full");
        run_seq(0);

        // overfill row 3
        fill_row(3, 8, 0);
        step(1, 0, 1, 3'd3, 0, e_load(8'h00, 0), "overfill fen");
        step(1, 0, 0, 3'd0, 0, e_load(8'h00, 1), "overfill err");
        step(1, 0, 0, 3'd0, 0, e_load(8'h00, 1), "err sticky");

        // start with row 5 one short
        step(1, 1, 0, 3'd0, 0, e_load(8'h00, 1), "clear A");
        for (int r = 0; r < 8; r++) fill_row(r, (r == 5) ? 7 : 8, 0);
        step(1, 0, 0, 3'd0, 1, e_load(8'h00, 0), "start partial");
        step(1, 0, 0, 3'd0, 0, e_load(8'h00, 1), "partial stays load");

        // clear in the middle of FEED
        step(1, 1, 0, 3'd0, 0, e_load(8'h00, 1), "clear B");
        for (int r = 0; r < 8; r++) fill_row(r, 8, 0);
        step(1, 0, 0, 3'd0, 1, e_load(8'h00, 0), "start C");
        for (int t = 0; t < 5; t++)
            step(1, 0, 0, 3'd0, 0, e_feed(feed_mask(t), 0), $sformatf("feed t%0d", t));
        step(1, 1, 0, 3'd0, 0, e_feed(8'h3F, 0), "feed t5 clear");
        step(1, 0, 0, 3'd0, 0, e_load(8'h00, 0), "after clear");

        // last write paired with start, then a retried start
        for (int r = 0; r < 8; r++) fill_row(r, (r == 7) ? 7 : 8, 0);
        step(1, 0, 1, 3'd7, 1, e_load(8'h80, 0), "last wr+start");
        step(1, 0, 0, 3'd0, 1, e_load(8'h00, 1), "start retry");
        run_seq(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
